// File: rtl/rot_angle_scheduler_if.sv
// Bundle between the angle scheduler, its requester and the shared CORDIC.
// The master side is the requester together with the CORDIC result path.
interface rot_angle_scheduler_if;
    logic        start;
    logic [15:0] angle_x;
    logic [15:0] angle_y;
    logic [15:0] angle_z;
    logic        cordic_phase_tvalid;
    logic [15:0] cordic_phase_tdata;
    logic        cordic_dout_tvalid;
    logic [31:0] cordic_dout_tdata;
    logic [15:0] sin_x;
    logic [15:0] cos_x;
    logic [15:0] sin_y;
    logic [15:0] cos_y;
    logic [15:0] sin_z;
    logic [15:0] cos_z;
    logic        busy;
    logic        done;
    logic        timeout_err;

    modport master (
        output start, angle_x, angle_y, angle_z,
        output cordic_dout_tvalid, cordic_dout_tdata,
        input  cordic_phase_tvalid, cordic_phase_tdata,
        input  sin_x, cos_x, sin_y, cos_y, sin_z, cos_z,
        input  busy, done, timeout_err
    );

    modport slave (
        input  start, angle_x, angle_y, angle_z,
        input  cordic_dout_tvalid, cordic_dout_tdata,
        output cordic_phase_tvalid, cordic_phase_tdata,
        output sin_x, cos_x, sin_y, cos_y, sin_z, cos_z,
        output busy, done, timeout_err
    );
endinterface

// File: rtl/rot_angle_scheduler.sv
// Time-shares one CORDIC sin/cos unit across the X, Y and Z rotation angles.
// Angles are range-wrapped, issued back-to-back, and results captured in order.
module rot_angle_scheduler #(
    parameter int PI_Q13     = 25736,
    parameter int TWO_PI_Q13 = 51472,
    parameter int TIMEOUT    = 64
) (
    input  logic                  CLK,
    input  logic                  rst,
    rot_angle_scheduler_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic signed [16:0] PI17  = 17'(PI_Q13);
    localparam logic signed [16:0] TWO17 = 17'(TWO_PI_Q13);

    logic [1:0]    r_state;
    logic [15:0]   r_ang_x;
    logic [15:0]   r_ang_y;
    logic [15:0]   r_ang_z;
    logic [1:0]    r_issue_cnt;
    logic [1:0]    r_ret_cnt;
    logic [TW-1:0] r_wait_cnt;
    logic          r_timeout_err;
    logic [15:0]   r_sin_x;
    logic [15:0]   r_cos_x;
    logic [15:0]   r_sin_y;
    logic [15:0]   r_cos_y;
    logic [15:0]   r_sin_z;
    logic [15:0]   r_cos_z;

    logic          w_idle;
    logic          w_issue;
    logic          w_wait;
    logic          w_done;
    logic          w_cap;
    logic          w_last_issue;
    logic          w_all_in;
    logic          w_expired;
    logic [1:0]    w_ret_nxt;
    logic [15:0]   w_wrap_x;
    logic [15:0]   w_wrap_y;
    logic [15:0]   w_wrap_z;
    logic [15:0]   w_phase;

    // A 16-bit input is never more than one turn outside [-pi, pi].
    function automatic logic [15:0] f_wrap(input logic [15:0] a);
        logic signed [16:0] v;
        v = signed'({a[15], a});
        if (v > PI17) begin
            v = v - TWO17;
        end else if (v < -PI17) begin
            v = v + TWO17;
        end
        return v[15:0];
    endfunction

    assign w_idle  = (r_state == S_IDLE);
    assign w_issue = (r_state == S_ISSUE);
    assign w_wait  = (r_state == S_WAIT);
    assign w_done  = (r_state == S_DONE);

    assign w_wrap_x = f_wrap(bus.angle_x);
    assign w_wrap_y = f_wrap(bus.angle_y);
    assign w_wrap_z = f_wrap(bus.angle_z);

    assign w_last_issue = (r_issue_cnt == 2'd2);
    assign w_cap        = bus.cordic_dout_tvalid
                        && (w_issue || w_wait)
                        && (r_ret_cnt != 2'd3);
    assign w_ret_nxt    = r_ret_cnt + 2'd1;
    assign w_all_in     = w_cap ? (w_ret_nxt == 2'd3)
                                : (r_ret_cnt == 2'd3);
    assign w_expired    = (r_wait_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        w_phase = 16'd0;
        if (w_issue) begin
            unique case (r_issue_cnt)
                2'd0:    w_phase = r_ang_x;
                2'd1:    w_phase = r_ang_y;
                default: w_phase = r_ang_z;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_ang_x       <= 16'd0;
            r_ang_y       <= 16'd0;
            r_ang_z       <= 16'd0;
            r_issue_cnt   <= 2'd0;
            r_ret_cnt     <= 2'd0;
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            unique case (1'b1)
                w_idle: begin
                    if (bus.start) begin
                        r_ang_x       <= w_wrap_x;
                        r_ang_y       <= w_wrap_y;
                        r_ang_z       <= w_wrap_z;
                        r_issue_cnt   <= 2'd0;
                        r_ret_cnt     <= 2'd0;
                        r_wait_cnt    <= '0;
                        r_timeout_err <= 1'b0;
                        r_state       <= S_ISSUE;
                    end
                end
                w_issue: begin
                    r_issue_cnt <= r_issue_cnt + 2'd1;
                    if (w_last_issue) begin
                        r_wait_cnt <= '0;
                        r_state    <= S_WAIT;
                    end
                end
                w_wait: begin
                    if (w_all_in) begin
                        r_state <= S_DONE;
                    end else if (w_expired) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TW'(1);
                    end
                end
                w_done: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            if (w_cap) begin
                r_ret_cnt <= w_ret_nxt;
            end
        end
    end

    // Results come back in issue order, so the return count names the axis.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_sin_x <= 16'd0;
            r_cos_x <= 16'd0;
            r_sin_y <= 16'd0;
            r_cos_y <= 16'd0;
            r_sin_z <= 16'd0;
            r_cos_z <= 16'd0;
        end else if (w_cap) begin
            unique case (r_ret_cnt)
                2'd0: begin
                    r_sin_x <= bus.cordic_dout_tdata[31:16];
                    r_cos_x <= bus.cordic_dout_tdata[15:0];
                end
                2'd1: begin
                    r_sin_y <= bus.cordic_dout_tdata[31:16];
                    r_cos_y <= bus.cordic_dout_tdata[15:0];
                end
                default: begin
                    r_sin_z <= bus.cordic_dout_tdata[31:16];
                    r_cos_z <= bus.cordic_dout_tdata[15:0];
                end
            endcase
        end
    end

    assign bus.cordic_phase_tvalid = w_issue;
    assign bus.cordic_phase_tdata  = w_phase;
    assign bus.busy                = !w_idle;
    assign bus.done                = w_done;
    assign bus.timeout_err         = r_timeout_err;
    assign bus.sin_x               = r_sin_x;
    assign bus.cos_x               = r_cos_x;
    assign bus.sin_y               = r_sin_y;
    assign bus.cos_y               = r_cos_y;
    assign bus.sin_z               = r_sin_z;
    assign bus.cos_z               = r_cos_z;

endmodule

// File: tb/tb_rot_angle_scheduler.sv
// Directed bench for rot_angle_scheduler with a behavioural latency-L CORDIC.
// Table of wrap/issue vectors plus hand sequences for timeout and reset.
module tb_rot_angle_scheduler;

    logic clk;
    logic rst;
    rot_angle_scheduler_if bus();

    rot_angle_scheduler dut (
        .CLK (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Behavioural CORDIC: fixed pipeline of depth L, optional drop of beat 3.
    int        lat = 5;
    bit        drop_third = 1'b0;
    bit [7:0]  pv;
    logic [31:0] pd [8];
    int        bseq = 0;

    function automatic logic [31:0] cordic_word(input logic [15:0] ph);
        real a;
        int s;
        int c;
        a = $itor($signed(ph)) / 8192.0;
        s = int'($sin(a) * 16384.0);
        c = int'($cos(a) * 16384.0);
        return {s[15:0], c[15:0]};
    endfunction

    function automatic int exp_sin(input int ph);
        logic [31:0] w;
        w = cordic_word(16'(ph));
        return int'($signed(w[31:16]));
    endfunction

    function automatic int exp_cos(input int ph);
        logic [31:0] w;
        w = cordic_word(16'(ph));
        return int'($signed(w[15:0]));
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 7; i > 0; i--) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
        pv[0] <= bus.cordic_phase_tvalid && !(drop_third && bseq == 2);
        pd[0] <= cordic_word(bus.cordic_phase_tdata);
        bseq  <= bus.cordic_phase_tvalid ? bseq + 1 : 0;
    end

    assign bus.cordic_dout_tvalid = pv[lat-1];
    assign bus.cordic_dout_tdata  = pv[lat-1] ? pd[lat-1] : 32'd0;

    int beats[$];
    int beat_cyc[$];

    always @(negedge clk) begin
        if (bus.cordic_phase_tvalid) begin
            beats.push_back(int'($signed(bus.cordic_phase_tdata)));
            beat_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    typedef struct {
        int ax; int ay; int az;
        int px; int py; int pz;
    } vec_t;

    vec_t tv[4];

    int cyc0;
    int done_at;
    int ndone;
    int busy_bad;
    int err_at;
    int err_k1;
    int snap_cosx;
    int snap_tv;

    task automatic do_run(input int ax, input int ay, input int az,
                          input int budget, input int restart_at);
        beats.delete();
        beat_cyc.delete();
        @(negedge clk);
        bus.start   = 1'b1;
        bus.angle_x = 16'(ax);
        bus.angle_y = 16'(ay);
        bus.angle_z = 16'(az);
        cyc0 = cyc;
        @(negedge clk);
        done_at = -1; ndone = 0; busy_bad = 0; err_at = -1;
        err_k1 = -1; snap_cosx = 0; snap_tv = 0;
        for (int k = 1; k <= budget; k++) begin
            bus.start = (k == restart_at);
            if (k == restart_at) begin
                bus.angle_x = 16'(1111);
                bus.angle_y = 16'(2222);
                bus.angle_z = 16'(3333);
            end
            if (k == 1) err_k1 = int'(bus.timeout_err);
            if (k == 3) begin
                snap_cosx = int'($signed(bus.cos_x));
                snap_tv   = int'(bus.cordic_phase_tvalid);
            end
            if (bus.done) begin
                ndone++;
                if (done_at < 0) done_at = k;
            end
            if (bus.timeout_err && err_at < 0) err_at = k;
            if (done_at < 0 && err_at < 0 && !bus.busy) busy_bad++;
            if (done_at > 0 && k == done_at + 1 && bus.busy) busy_bad++;
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic chk_beats(input string nm, input int px, input int py, input int pz);
        int exp_p[3];
        exp_p[0] = px; exp_p[1] = py; exp_p[2] = pz;
        chk({nm, "_nbeats"}, beats.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < beats.size()) begin
                chk($sformatf("%s_beat%0d", nm, i), beats[i], exp_p[i]);
                chk($sformatf("%s_beatcyc%0d", nm, i), beat_cyc[i] - cyc0, i + 1);
            end
        end
    endtask

    task automatic chk_res(input string nm, input int px, input int py, input int pz);
        chk({nm, "_sin_x"}, int'($signed(bus.sin_x)), exp_sin(px));
        chk({nm, "_cos_x"}, int'($signed(bus.cos_x)), exp_cos(px));
        chk({nm, "_sin_y"}, int'($signed(bus.sin_y)), exp_sin(py));
        chk({nm, "_cos_y"}, int'($signed(bus.cos_y)), exp_cos(py));
        chk({nm, "_sin_z"}, int'($signed(bus.sin_z)), exp_sin(pz));
        chk({nm, "_cos_z"}, int'($signed(bus.cos_z)), exp_cos(pz));
    endtask

    initial begin
        int late;
        int seen;

        tv[0] = '{0, 12868, -12868, 0, 12868, -12868};
        tv[1] = '{25736, 25737, -30000, 25736, -25735, 21472};
        tv[2] = '{-25736, -25737, 32767, -25736, 25735, -18705};
        tv[3] = '{1000, -32768, -1000, 1000, 18704, -1000};

        rst = 1'b0;
        bus.start = 1'b0;
        bus.angle_x = 16'd0;
        bus.angle_y = 16'd0;
        bus.angle_z = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_tvalid", int'(bus.cordic_phase_tvalid), 0);
        chk("rst_tdata", int'(bus.cordic_phase_tdata), 0);
        chk("rst_terr", int'(bus.timeout_err), 0);
        chk("rst_sin_x", int'(bus.sin_x), 0);
        chk("rst_cos_z", int'(bus.cos_z), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        lat = 5;
        for (int v = 0; v < 4; v++) begin
            do_run(tv[v].ax, tv[v].ay, tv[v].az, 20, -1);
            chk_beats($sformatf("v%0d", v), tv[v].px, tv[v].py, tv[v].pz);
            chk($sformatf("v%0d_done_at", v), done_at, 9);
            chk($sformatf("v%0d_ndone", v), ndone, 1);
            chk($sformatf("v%0d_busy", v), busy_bad, 0);
            chk_res($sformatf("v%0d", v), tv[v].px, tv[v].py, tv[v].pz);
            if (v == 0) begin
                chk("basic_cos_x", int'($signed(bus.cos_x)), 16384);
                chk("basic_sin_x", int'($signed(bus.sin_x)), 0);
                chk("basic_sin_y", int'($signed(bus.sin_y)), 16384);
                chk("basic_cos_y", int'($signed(bus.cos_y)), 0);
                chk("basic_sin_z", int'($signed(bus.sin_z)), -16384);
            end
        end

        // Third result never comes back: abort after TIMEOUT cycles in WAIT.
        drop_third = 1'b1;
        do_run(0, 12868, -12868, 80, -1);
        drop_third = 1'b0;
        chk("to_err_at", err_at, 68);
        chk("to_ndone", ndone, 0);
        chk("to_busy", int'(bus.busy), 0);
        chk("to_sin_y", int'($signed(bus.sin_y)), 16384);
        chk("to_sin_z_kept", int'($signed(bus.sin_z)), exp_sin(-1000));
        chk("to_cos_z_kept", int'($signed(bus.cos_z)), exp_cos(-1000));

        // Latency 1: first result lands while still issuing.
        lat = 1;
        do_run(tv[1].ax, tv[1].ay, tv[1].az, 12, -1);
        chk("l1_err_cleared", err_k1, 0);
        chk("l1_tv_k3", snap_tv, 1);
        chk("l1_cosx_k3", snap_cosx, exp_cos(25736));
        chk_beats("l1", tv[1].px, tv[1].py, tv[1].pz);
        chk("l1_done_at", done_at, 5);
        chk("l1_ndone", ndone, 1);
        chk("l1_busy", busy_bad, 0);
        chk_res("l1", tv[1].px, tv[1].py, tv[1].pz);
        repeat (3) @(negedge clk);

        // Second start during WAIT must be ignored.
        lat = 5;
        do_run(tv[2].ax, tv[2].ay, tv[2].az, 20, 5);
        chk_beats("rb", tv[2].px, tv[2].py, tv[2].pz);
        chk("rb_done_at", done_at, 9);
        chk("rb_ndone", ndone, 1);
        chk("rb_busy", busy_bad, 0);
        chk("rb_idle", int'(bus.busy), 0);
        chk_res("rb", tv[2].px, tv[2].py, tv[2].pz);

        // Asynchronous reset in WAIT; late results must be dropped.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.angle_x = 16'(tv[1].ax);
        bus.angle_y = 16'(tv[1].ay);
        bus.angle_z = 16'(tv[1].az);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mr_wait_busy", int'(bus.busy), 1);
        #2 rst = 1'b0;
        #1;
        chk("mr_busy", int'(bus.busy), 0);
        chk("mr_done", int'(bus.done), 0);
        chk("mr_sin_x", int'(bus.sin_x), 0);
        chk("mr_cos_y", int'(bus.cos_y), 0);
        chk("mr_tvalid", int'(bus.cordic_phase_tvalid), 0);
        @(negedge clk);
        rst = 1'b1;
        late = 0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.cordic_dout_tvalid) seen++;
            if (bus.busy || bus.done || bus.sin_x != 16'd0
                || bus.cos_x != 16'd0 || bus.cos_z != 16'd0) late++;
        end
        chk("mr_late_seen", seen, 3);
        chk("mr_late_ignored", late, 0);

        do_run(tv[3].ax, tv[3].ay, tv[3].az, 20, -1);
        chk_beats("pr", tv[3].px, tv[3].py, tv[3].pz);
        chk("pr_done_at", done_at, 9);
        chk("pr_ndone", ndone, 1);
        chk_res("pr", tv[3].px, tv[3].py, tv[3].pz);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
